instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and program loader: accepts abstract instruction descriptors (op, rd, rs1, rs2, imm) over a valid/ready stream, packs each into a 32-bit machine word, and writes the words to consecutive instruction-memory addresses. It produces exactly the encodings the CPU control decoder consumes: R-type, I-type, load, store, LUI, BEQ, BNE, JAL and JALR. It sits between the testbench or boot-loader front end and the instruction memory write port.

---
 rtl/instr_encoder_pkg.sv | 34 +++
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder_pack.sv | 76 +++++++
 rtl/instr_encoder.sv | 109 ++++++++++
 tb/tb_instr_encoder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared op codes, RV32I opcode constants and loader state type.
package encoder_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD  = 4'd0;
  localparam op_t OP_SUB  = 4'd1;
  localparam op_t OP_AND  = 4'd2;
  localparam op_t OP_OR   = 4'd3;
  localparam op_t OP_SLT  = 4'd4;
  localparam op_t OP_ADDI = 4'd5;
  localparam op_t OP_LW   = 4'd6;
  localparam op_t OP_SW   = 4'd7;
  localparam op_t OP_LUI  = 4'd8;
  localparam op_t OP_BEQ  = 4'd9;
  localparam op_t OP_BNE  = 4'd10;
  localparam op_t OP_JAL  = 4'd11;
  localparam op_t OP_JALR = 4'd12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor stream plus instruction-memory write port.
// master: front end / memory side; slave: the encoder.
interface instr_encoder_if
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic                  in_valid;
  logic                  in_ready;
  op_t                   in_op;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  in_last;
  logic                  mem_we;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational descriptor packer: builds the RV32I word and flags
// out-of-range immediates and illegal ops. Low imm bits are encoded regardless.
module instr_pack
  import encoder_pkg::*;
(
  input  op_t         i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_range_err,
  output logic        o_illegal
);
  logic signed [31:0] w_imm;
  logic               w_i_bad;
  logic               w_b_bad;
  logic               w_j_bad;
  logic               w_u_bad;

  assign w_imm   = $signed(i_imm);
  assign w_i_bad = (w_imm < -32'sd2048) || (w_imm > 32'sd2047);
  assign w_b_bad = (w_imm < -32'sd4096) || (w_imm > 32'sd4094) || i_imm[0];
  assign w_j_bad = (w_imm < -32'sd1048576) || (w_imm > 32'sd1048574) || i_imm[0];
  assign w_u_bad = |i_imm[11:0];

  // Select format, funct fields and range rule per op
  always_comb begin
    o_word      = NOP;
    o_range_err = 1'b0;
    o_illegal   = 1'b0;
    case (i_op)
      OP_ADD:  o_word = {7'b0000000, i_rs2, i_rs1, 3'b000, i_rd, OPC_OP};
      OP_SUB:  o_word = {7'b0100000, i_rs2, i_rs1, 3'b000, i_rd, OPC_OP};
      OP_AND:  o_word = {7'b0000000, i_rs2, i_rs1, 3'b111, i_rd, OPC_OP};
      OP_OR:   o_word = {7'b0000000, i_rs2, i_rs1, 3'b110, i_rd, OPC_OP};
      OP_SLT:  o_word = {7'b0000000, i_rs2, i_rs1, 3'b010, i_rd, OPC_OP};
      OP_ADDI: begin
        o_word      = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_OP_IMM};
        o_range_err = w_i_bad;
      end
      OP_LW: begin
        o_word      = {i_imm[11:0], i_rs1, 3'b010, i_rd, OPC_LOAD};
        o_range_err = w_i_bad;
      end
      OP_SW: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OPC_STORE};
        o_range_err = w_i_bad;
      end
      OP_LUI: begin
        o_word      = {i_imm[31:12], i_rd, OPC_LUI};
        o_range_err = w_u_bad;
      end
      OP_BEQ: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000, i_imm[4:1], i_imm[11],
                       OPC_BRANCH};
        o_range_err = w_b_bad;
      end
      OP_BNE: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b001, i_imm[4:1], i_imm[11],
                       OPC_BRANCH};
        o_range_err = w_b_bad;
      end
      OP_JAL: begin
        o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
        o_range_err = w_j_bad;
      end
      OP_JALR: begin
        o_word      = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR};
        o_range_err = w_i_bad;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors, encodes them and writes them to
// consecutive word addresses through a one-entry output register.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  instr_encoder_if.slave        io_bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_wrapped
);
  localparam logic [ADDR_WIDTH-1:0] TopWord = ~ADDR_WIDTH'(3);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_done;
  logic                  r_err;
  logic                  r_wrapped;

  logic [31:0]           w_word;
  logic                  w_range_err;
  logic                  w_illegal;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_wr_fire;

  instr_pack u_pack (
    .i_op        (io_bus.in_op),
    .i_rd        (io_bus.in_rd),
    .i_rs1       (io_bus.in_rs1),
    .i_rs2       (io_bus.in_rs2),
    .i_imm       (io_bus.in_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err),
    .o_illegal   (w_illegal)
  );

  // Output register may be refilled in the same cycle it drains
  assign w_in_ready = (r_state == StRun) && (!r_mem_we || io_bus.mem_ready);
  assign w_accept   = w_in_ready && io_bus.in_valid;
  assign w_wr_fire  = r_mem_we && io_bus.mem_ready;

  // Loader FSM, output stage, address counter and sticky flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_addr    <= i_base_addr & ~ADDR_WIDTH'(3);
            r_err     <= 1'b0;
            r_wrapped <= 1'b0;
            r_state   <= StRun;
          end
        end
        StRun: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word;
            r_addr      <= r_addr + ADDR_WIDTH'(4);
            if (r_addr == TopWord) r_wrapped <= 1'b1;
            if (w_range_err || w_illegal) r_err <= 1'b1;
            if (io_bus.in_last) r_state <= StDrain;
          end else if (w_wr_fire) begin
            r_mem_we <= 1'b0;
          end
        end
        StDrain: begin
          if (w_wr_fire) begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign o_busy           = (r_state == StRun) || (r_state == StDrain);
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_wrapped        = r_wrapped;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench: two loaders (10-bit and 4-bit address) fed identical stimulus,
// checked against an arithmetic reference encoder and address model.
module tb_instr_encoder;
  import encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        busy10, done10, err10, wr10;
  logic        busy4, done4, err4, wr4;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_acc_cyc;

  logic [3:0]  d_op[64];
  logic [4:0]  d_rd[64], d_rs1[64], d_rs2[64];
  logic [31:0] d_imm[64];

  logic [9:0]  cap_a10[$];
  logic [31:0] cap_d10[$];
  int          cap_c10[$];
  logic [3:0]  cap_a4[$];
  logic [31:0] cap_d4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder_if #(.ADDR_WIDTH(10)) if10 ();
  instr_encoder_if #(.ADDR_WIDTH(4))  if4 ();

  assign if10.in_valid = in_valid;   assign if4.in_valid = in_valid;
  assign if10.in_op = in_op;         assign if4.in_op = in_op;
  assign if10.in_rd = in_rd;         assign if4.in_rd = in_rd;
  assign if10.in_rs1 = in_rs1;       assign if4.in_rs1 = in_rs1;
  assign if10.in_rs2 = in_rs2;       assign if4.in_rs2 = in_rs2;
  assign if10.in_imm = in_imm;       assign if4.in_imm = in_imm;
  assign if10.in_last = in_last;     assign if4.in_last = in_last;
  assign if10.mem_ready = mem_ready; assign if4.mem_ready = mem_ready;

  instr_encoder #(.ADDR_WIDTH(10)) u_dut10 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr), .io_bus(if10),
    .o_busy(busy10), .o_done(done10), .o_err(err10), .o_wrapped(wr10)
  );

  instr_encoder #(.ADDR_WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr[3:0]), .io_bus(if4),
    .o_busy(busy4), .o_done(done4), .o_err(err4), .o_wrapped(wr4)
  );

  // Record every write that the memory accepts at the coming edge
  always @(negedge clk) begin
    if (if10.mem_we && if10.mem_ready) begin
      cap_a10.push_back(if10.mem_addr);
      cap_d10.push_back(if10.mem_wdata);
      cap_c10.push_back(cyc);
    end
    if (if4.mem_we && if4.mem_ready) begin
      cap_a4.push_back(if4.mem_addr);
      cap_d4.push_back(if4.mem_wdata);
    end
  end

  // Reference encoder built from field positions with shifts and masks
  function automatic void ref_encode(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm, output logic [31:0] word,
                                     output bit bad);
    int s;
    logic [31:0] r, a, b, ib;
    s = $signed(imm);
    r = 32'(rd) << 7;
    a = 32'(rs1) << 15;
    b = 32'(rs2) << 20;
    ib = (imm & 32'hFFF) << 20;
    bad = 1'b0;
    case (op)
      4'd0: word = 32'h33 | r | a | b;
      4'd1: word = 32'h33 | r | a | b | 32'h4000_0000;
      4'd2: word = 32'h33 | r | 32'h7000 | a | b;
      4'd3: word = 32'h33 | r | 32'h6000 | a | b;
      4'd4: word = 32'h33 | r | 32'h2000 | a | b;
      4'd5, 4'd6, 4'd12: begin
        word = (op == 4'd5 ? 32'h13 : (op == 4'd6 ? 32'h2003 : 32'h67)) | r | a | ib;
        bad = (s < -2048) || (s > 2047);
      end
      4'd7: begin
        word = 32'h2023 | ((imm & 32'h1F) << 7) | a | b | (((imm >> 5) & 32'h7F) << 25);
        bad = (s < -2048) || (s > 2047);
      end
      4'd8: begin
        word = 32'h37 | r | (imm & 32'hFFFF_F000);
        bad = (imm & 32'hFFF) != 0;
      end
      4'd9, 4'd10: begin
        word = 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) |
               (op == 4'd10 ? 32'h1000 : 32'h0) | a | b | (((imm >> 5) & 32'h3F) << 25) |
               (((imm >> 12) & 32'h1) << 31);
        bad = (s < -4096) || (s > 4094) || ((imm & 32'h1) != 0);
      end
      4'd11: begin
        word = 32'h6F | r | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20) |
               (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
        bad = (s < -1048576) || (s > 1048574) || ((imm & 32'h1) != 0);
      end
      default: begin
        word = 32'h13;
        bad = 1'b1;
      end
    endcase
  endfunction

  task automatic set_desc(input int k, input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    d_op[k] = op; d_rd[k] = rd; d_rs1[k] = rs1; d_rs2[k] = rs2; d_imm[k] = imm;
  endtask

  // One load session from start to done, checked against the model
  task automatic run_session(input int n, input logic [9:0] base, input bit gaps,
                             input bit rand_ready, input bit stall2);
    int idx, guard, dones10, dones4, done_cyc, stall_left;
    bit acc, bad, stalling, exp_err, exp_wr10, exp_wr4;
    logic [31:0] w, st_d;
    logic [9:0] st_a10, ea10;
    logic [3:0] st_a4;
    cap_a10.delete(); cap_d10.delete(); cap_c10.delete(); cap_a4.delete(); cap_d4.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; guard = 0; dones10 = 0; dones4 = 0; done_cyc = -1; stall_left = 3;
    stalling = 1'b0; first_acc_cyc = -1;
    while (dones10 == 0 && guard < 3000) begin
      in_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
      if (idx < n) begin
        in_op = d_op[idx]; in_rd = d_rd[idx]; in_rs1 = d_rs1[idx]; in_rs2 = d_rs2[idx];
        in_imm = d_imm[idx]; in_last = (idx == n - 1);
      end
      if (stall2 && cap_d10.size() == 1 && stall_left > 0 && if10.mem_we) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (stall2 && !mem_ready && cap_d10.size() == 1) begin
        n_checks++;
        if (if10.in_ready !== 1'b0 || if10.mem_we !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_handshake: in_ready=%b mem_we=%b expected 0/1",
                   if10.in_ready, if10.mem_we);
        end
        if (!stalling) begin
          st_a10 = if10.mem_addr; st_a4 = if4.mem_addr; st_d = if10.mem_wdata;
          stalling = 1'b1;
        end else begin
          n_checks++;
          if (if10.mem_addr !== st_a10 || if4.mem_addr !== st_a4 || if10.mem_wdata !== st_d) begin
            n_fail++;
            $display("FAIL stall_stable: addr=%h/%h data=%h expected %h/%h %h",
                     if10.mem_addr, if4.mem_addr, if10.mem_wdata, st_a10, st_a4, st_d);
          end
        end
      end
      acc = in_valid && if10.in_ready;
      if (acc && idx == 0) first_acc_cyc = cyc;
      if (done10) begin dones10++; done_cyc = cyc; end
      if (done4) dones4++;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (guard >= 3000) begin
      n_fail++;
      $display("FAIL session_timeout: accepted %0d of %0d, done never seen", idx, n);
    end
    @(negedge clk);
    n_checks++;
    if (done10 !== 1'b0 || busy10 !== 1'b0 || dones4 !== 1) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b dones4=%0d expected 0 0 1",
               done10, busy10, dones4);
    end
    n_checks++;
    if (cap_d10.size() != n || cap_d4.size() != n) begin
      n_fail++;
      $display("FAIL write_count: got %0d/%0d expected %0d", cap_d10.size(), cap_d4.size(), n);
    end
    exp_err = 1'b0; exp_wr10 = 1'b0; exp_wr4 = 1'b0;
    for (int k = 0; k < n; k++) begin
      ref_encode(d_op[k], d_rd[k], d_rs1[k], d_rs2[k], d_imm[k], w, bad);
      ea10 = (base & 10'h3FC) + 10'(4 * k);
      exp_err |= bad;
      exp_wr10 |= (ea10 == 10'h3FC);
      exp_wr4 |= (ea10[3:0] == 4'hC);
      if (k < cap_d10.size() && k < cap_d4.size()) begin
        n_checks++;
        if (cap_d10[k] !== w || cap_a10[k] !== ea10 || cap_d4[k] !== w ||
            cap_a4[k] !== ea10[3:0]) begin
          n_fail++;
          $display("FAIL write_%0d: got %h@%h / %h@%h expected %h@%h / %h@%h", k, cap_d10[k],
                   cap_a10[k], cap_d4[k], cap_a4[k], w, ea10, w, ea10[3:0]);
        end
      end
    end
    n_checks++;
    if (err10 !== exp_err || err4 !== exp_err || wr10 !== exp_wr10 || wr4 !== exp_wr4) begin
      n_fail++;
      $display("FAIL flags: err=%b/%b wrapped=%b/%b expected err=%b wrapped=%b/%b",
               err10, err4, wr10, wr4, exp_err, exp_wr10, exp_wr4);
    end
    if (cap_c10.size() > 0) begin
      n_checks++;
      if (done_cyc !== cap_c10[cap_c10.size() - 1] + 1) begin
        n_fail++;
        $display("FAIL done_latency: done at %0d expected %0d", done_cyc,
                 cap_c10[cap_c10.size() - 1] + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (if10.mem_we !== 1'b0 || if10.mem_addr !== 10'h0 || if10.mem_wdata !== 32'h0 ||
        if10.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_port: we=%b addr=%h data=%h rdy=%b expected all 0",
               if10.mem_we, if10.mem_addr, if10.mem_wdata, if10.in_ready);
    end
    n_checks++;
    if (busy10 !== 1'b0 || done10 !== 1'b0 || err10 !== 1'b0 || wr10 !== 1'b0 ||
        if4.mem_we !== 1'b0 || wr4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b wrapped=%b we4=%b expected all 0",
               busy10, done10, err10, wr10, if4.mem_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_addi();
    set_desc(0, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    run_session(1, 10'h000, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cap_d10.size() < 1 || cap_d10[0] !== 32'h0050_0093 || cap_a10[0] !== 10'h000) begin
      n_fail++;
      $display("FAIL addi_word: got %h@%h expected 00500093@000",
               cap_d10.size() > 0 ? cap_d10[0] : 32'hx, cap_a10.size() > 0 ? cap_a10[0] : 10'hx);
    end
    n_checks++;
    if (cap_c10.size() < 1 || cap_c10[0] !== first_acc_cyc + 1) begin
      n_fail++;
      $display("FAIL addi_latency: write cycle %0d expected %0d",
               cap_c10.size() > 0 ? cap_c10[0] : -1, first_acc_cyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    set_desc(0, OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    set_desc(1, OP_SW, 5'd0, 5'd1, 5'd2, 32'd8);
    run_session(2, 10'h000, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cap_d10.size() < 2 || cap_d10[0] !== 32'h4020_81B3 || cap_d10[1] !== 32'h0020_A423 ||
        cap_a10[1] !== 10'h004 || err10 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_words: got %0d writes err=%b expected 402081B3@000 0020A423@004 err=0",
               cap_d10.size(), err10);
    end
    n_checks++;
    if (cap_c10.size() < 2 || cap_c10[1] !== cap_c10[0] + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: second write not on the following cycle");
    end
  endtask

  task automatic test_branch_jal();
    set_desc(0, OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd8);
    set_desc(1, OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048);
    set_desc(2, OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd5);
    run_session(3, 10'h100, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cap_d10.size() < 2 || cap_d10[0] !== 32'hFE20_8CE3 || cap_d10[1] !== 32'h0010_00EF ||
        err10 !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_jal: err=%b expected FE208CE3 001000EF err=1", err10);
    end
  endtask

  task automatic test_wrap_stall();
    for (int k = 0; k < 3; k++) set_desc(k, OP_ADDI, 5'(k + 1), 5'd2, 5'd0, 32'(k * 3));
    run_session(3, 10'h00C, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (cap_a4.size() < 3 || cap_a4[0] !== 4'hC || cap_a4[1] !== 4'h0 || cap_a4[2] !== 4'h4 ||
        wr4 !== 1'b1 || wr10 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: wrapped=%b/%b expected C,0,4 wrapped4=1 wrapped10=0", wr4, wr10);
    end
  endtask

  task automatic test_illegal();
    set_desc(0, 4'd14, 5'd7, 5'd3, 5'd4, 32'h1234);
    run_session(1, 10'h040, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cap_d10.size() < 1 || cap_d10[0] !== 32'h0000_0013 || err10 !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_op: err=%b expected 00000013 err=1", err10);
    end
    set_desc(0, OP_OR, 5'd7, 5'd3, 5'd4, 32'h0);
    run_session(1, 10'h080, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err10 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b expected 0", err10);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h020;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_op = 4'd14; in_last = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if10.mem_we !== 1'b1 || busy10 !== 1'b1 || err10 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: we=%b busy=%b err=%b expected 1 1 1", if10.mem_we, busy10, err10);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if10.mem_we !== 1'b0 || busy10 !== 1'b0 || if10.in_ready !== 1'b0 || err10 !== 1'b0 ||
        if10.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_post: we=%b busy=%b rdy=%b err=%b data=%h expected 0 0 0 0 0",
               if10.mem_we, busy10, if10.in_ready, err10, if10.mem_wdata);
    end
    set_desc(0, OP_LUI, 5'd5, 5'd0, 5'd0, 32'hABCDE000);
    set_desc(1, OP_JALR, 5'd1, 5'd5, 5'd0, -32'sd4);
    run_session(2, 10'h3FC, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int bnd[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098, 1048574, -1048576,
                    1048576, 4096};
    int n;
    logic [31:0] imm;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 14);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          1: imm = 32'(bnd[$urandom_range(0, 11)]);
          2: imm = $urandom;
          3: imm = $urandom & 32'hFFFF_F000;
          4: imm = 32'(2 * $urandom_range(0, 4095)) - 32'd4096;
          default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'h1;
        endcase
        set_desc(k, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15))
                                                : 4'($urandom_range(0, 12)),
                 5'($urandom), 5'($urandom), 5'($urandom), imm);
      end
      run_session(n, 10'($urandom_range(0, 1023)), 1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_jal();
    test_wrap_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
